seq_alu: RTL

Parametrised, multi-cycle successor to the datapath ALU.
- Keeps the eight single-cycle operations and the A/B operand-source selection.
- Adds logical/arithmetic right shift, iterative multiply (low/high), and unsigned divide/remainder.
- Sits between register-read and write-back. Uses a valid/ready handshake so the pipeline control unit stalls while a multi-cycle op is in flight.

---
 rtl/seq_alu_pkg.sv | 24 ++
 rtl/seq_alu_iter.sv | 51 +++++
 rtl/seq_alu.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode/state enums and divide-by-zero quotient for seq_alu
package seq_alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_SLL   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_AND   = 4'b0100,
    OP_EQ    = 4'b0101,
    OP_SLT   = 4'b0110,
    OP_XOR   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_MULLO = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  // All-ones quotient of width w; callers truncate to their datapath width.
  function automatic logic [1023:0] DIV0_QUOT(input int unsigned w);
    return (1024'(1) << w) - 1024'(1);
  endfunction
endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: shared iterative shift-add multiply / restoring divide datapath
// Ports: clk, rst_n (async active-low); start_i loads operands and counter;
// flush_i clears the counter; run_i steps one bit per cycle; div_i selects divide;
// a_i/b_i operands; last_o marks the final step; acc_d_o is the next accumulator
// ({hi,lo} = product, or {remainder,quotient}).
module seq_alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic                 run_i,
  input  logic                 div_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   acc_d_o
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     sum, rem, diff;
  assign last_o = cnt_q == '0;
  // Multiply adds B into the high half when the lsb is set, then shifts right.
  // Divide shifts the next dividend bit into the remainder and restores on borrow.
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rem - {1'b0, b_q};
    acc_d_o = !div_i ? {sum, acc_q[WIDTH-1:1]} :
              diff[WIDTH] ? {rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                            {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q <= {{WIDTH{1'b0}}, a_i};
      b_q   <= b_i;
      cnt_q <= CW'(WIDTH - 1);
    end else if (run_i) begin
      acc_q <= acc_d_o;
      cnt_q <= last_o ? '0 : cnt_q - 1'b1;
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshake between register-read and write-back
// Ports: clk, rst_n (async active-low); in_valid/in_ready request handshake; flush aborts;
// alu_op opcode; read_data1/read_data2/in_ext/sa operand sources selected by
// src_a_sel/src_b_sel; out_valid/out_ready result handshake; result and zero registered.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] in_ext,
  input  logic [SHW-1:0]   sa,
  input  logic             src_a_sel,
  input  logic             src_b_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam logic [WIDTH-1:0] DIV0_Q = WIDTH'(DIV0_QUOT(WIDTH));
  state_e             state_q;
  alu_op_e            op, op_q;
  logic               out_valid_q, zero_q, accept, is_mul, is_div, multi, fin, last;
  logic [WIDTH-1:0]   a, b, single, result_q, fin_val;
  logic [2*WIDTH-1:0] acc_d;
  assign op       = alu_op_e'(alu_op);
  assign a        = src_a_sel ? WIDTH'(sa) : read_data1;
  assign b        = src_b_sel ? in_ext : read_data2;
  assign in_ready = rst_n && state_q == IDLE && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign is_mul   = op == OP_MULLO || op == OP_MULHU;
  assign is_div   = op == OP_DIVU || op == OP_REMU;
  // Divide by zero skips iteration and completes like a single-cycle op.
  assign multi    = is_mul || (is_div && b != '0);
  assign fin      = state_q != IDLE && last;
  assign fin_val  = (op_q == OP_MULHU || op_q == OP_REMU) ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  always_comb begin
    single = '0;
    case (op)
      OP_ADD:  single = a + b;
      OP_SUB:  single = a - b;
      OP_SLL:  single = b << sa;
      OP_OR:   single = a | b;
      OP_AND:  single = a & b;
      OP_EQ:   single = {{(WIDTH-1){1'b0}}, a == b};
      OP_SLT:  single = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_XOR:  single = a ^ b;
      OP_SRL:  single = b >> sa;
      OP_SRA:  single = $signed(b) >>> sa;
      OP_DIVU: single = DIV0_Q;
      OP_REMU: single = a;
      default: single = '0;
    endcase
  end
  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && multi),
    .flush_i (flush),
    .run_i   (state_q != IDLE),
    .div_i   (state_q == DIV),
    .a_i     (a),
    .b_i     (b),
    .last_o  (last),
    .acc_d_o (acc_d)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        if (multi) begin
          state_q <= is_mul ? MUL : DIV;
        end else begin
          result_q <= single;
          zero_q   <= single == '0;
        end
      end else if (fin) begin
        result_q <= fin_val;
        zero_q   <= fin_val == '0;
        state_q  <= IDLE;
      end
      out_valid_q <= (accept && !multi) || fin || (out_valid_q && !out_ready);
    end
endmodule
